// File: rtl/video_arb_pkg.sv
// Shared owner encoding for the video DRAM slot arbiter.
package video_arb_pkg;

    localparam int OWNER_W = 3;

    localparam logic [OWNER_W-1:0] OWN_IDLE = 3'd0;
    localparam logic [OWNER_W-1:0] OWN_VID  = 3'd1;
    localparam logic [OWNER_W-1:0] OWN_TM   = 3'd2;
    localparam logic [OWNER_W-1:0] OWN_TS   = 3'd3;
    localparam logic [OWNER_W-1:0] OWN_CPU  = 3'd4;

endpackage

// File: rtl/video_arb_pick.sv
// Combinational slot winner selection: raster first, starved Z80, then the
// TM/TS round-robin pair (Z80 optionally ahead of TS), then Z80, else idle.
module video_arb_pick
    import video_arb_pkg::*;
(
    input  logic               vid_go,
    input  logic               tm_req,
    input  logic               ts_req,
    input  logic               cpu_req,
    input  logic               rr,
    input  logic               ts_z80_lp,
    input  logic               starve,
    output logic [OWNER_W-1:0] owner
);

    always_comb begin
        owner = OWN_IDLE;
        if (vid_go) begin
            owner = OWN_VID;
        end else if (cpu_req && starve) begin
            owner = OWN_CPU;
        end else if (!rr) begin
            if (tm_req)                      owner = OWN_TM;
            else if (cpu_req && ts_z80_lp)   owner = OWN_CPU;
            else if (ts_req)                 owner = OWN_TS;
            else if (cpu_req)                owner = OWN_CPU;
        end else begin
            if (cpu_req && ts_z80_lp)        owner = OWN_CPU;
            else if (ts_req)                 owner = OWN_TS;
            else if (tm_req)                 owner = OWN_TM;
            else if (cpu_req)                owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/video_dram_arb.sv
// Video DRAM slot arbiter: decides at slot_pre, holds the registered grant
// through slot_stb and emits the owner's completion pulse at slot_stb.
module video_dram_arb
    import video_arb_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 8,
    parameter int AW           = 21
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               slot_pre,
    input  logic               slot_stb,
    input  logic               vid_go,
    input  logic [AW-1:0]      vid_addr,
    input  logic               tm_req,
    input  logic [AW-1:0]      tm_addr,
    input  logic               ts_req,
    input  logic [AW-1:0]      ts_addr,
    input  logic               ts_z80_lp,
    input  logic               cpu_req,
    input  logic [AW-1:0]      cpu_addr,
    output logic               dram_req,
    output logic [AW-1:0]      dram_addr,
    output logic [OWNER_W-1:0] owner,
    output logic               vid_next,
    output logic               tm_next,
    output logic               ts_pre_next,
    output logic               ts_next,
    output logic               cpu_next
);

    logic               rr;
    logic [3:0]         wait_cnt;
    logic               starve;
    logic [OWNER_W-1:0] pick;
    logic [AW-1:0]      pick_addr;

    assign starve = (wait_cnt == 4'(CPU_MAX_WAIT));

    video_arb_pick u_pick (
        .vid_go    (vid_go),
        .tm_req    (tm_req),
        .ts_req    (ts_req),
        .cpu_req   (cpu_req),
        .rr        (rr),
        .ts_z80_lp (ts_z80_lp),
        .starve    (starve),
        .owner     (pick)
    );

    always_comb begin
        pick_addr = '0;
        case (pick)
            OWN_VID: pick_addr = vid_addr;
            OWN_TM:  pick_addr = tm_addr;
            OWN_TS:  pick_addr = ts_addr;
            OWN_CPU: pick_addr = cpu_addr;
            default: pick_addr = '0;
        endcase
    end

    // slot_pre takes precedence so a back-to-back slot loads without a gap
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            dram_req  <= 1'b0;
            dram_addr <= '0;
            owner     <= OWN_IDLE;
            rr        <= 1'b0;
            wait_cnt  <= '0;
        end else if (slot_pre) begin
            owner     <= pick;
            dram_addr <= pick_addr;
            dram_req  <= (pick != OWN_IDLE);
            if (pick == OWN_TM)
                rr <= 1'b1;
            else if (pick == OWN_TS)
                rr <= 1'b0;
            if (!cpu_req || pick == OWN_CPU)
                wait_cnt <= '0;
            else if (!starve)
                wait_cnt <= wait_cnt + 4'd1;
        end else if (slot_stb) begin
            owner    <= OWN_IDLE;
            dram_req <= 1'b0;
        end
    end

    assign vid_next    = slot_stb && (owner == OWN_VID);
    assign tm_next     = slot_stb && (owner == OWN_TM);
    assign ts_next     = slot_stb && (owner == OWN_TS);
    assign cpu_next    = slot_stb && (owner == OWN_CPU);
    assign ts_pre_next = res_n && slot_pre && (pick == OWN_TS);

    a_no_overlap: assert property (@(posedge clk) disable iff (!res_n)
        !(slot_pre && dram_req && !slot_stb));

endmodule

// File: tb/tb_video_dram_arb.sv
// Scoreboard bench for video_dram_arb: a reference arbiter predicts each grant
// at slot_pre and the prediction is checked when its slot_stb arrives.
module tb_video_dram_arb;

    localparam int AW   = 21;
    localparam int MAXW = 8;

    localparam logic [2:0] O_IDLE = 3'd0;
    localparam logic [2:0] O_VID  = 3'd1;
    localparam logic [2:0] O_TM   = 3'd2;
    localparam logic [2:0] O_TS   = 3'd3;
    localparam logic [2:0] O_CPU  = 3'd4;

    logic          clk = 1'b0;
    logic          res_n;
    logic          slot_pre, slot_stb;
    logic          vid_go, tm_req, ts_req, cpu_req, ts_z80_lp;
    logic [AW-1:0] vid_addr, tm_addr, ts_addr, cpu_addr;
    logic          dram_req;
    logic [AW-1:0] dram_addr;
    logic [2:0]    owner;
    logic          vid_next, tm_next, ts_pre_next, ts_next, cpu_next;

    video_dram_arb #(.CPU_MAX_WAIT(MAXW), .AW(AW)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .slot_pre   (slot_pre),
        .slot_stb   (slot_stb),
        .vid_go     (vid_go),
        .vid_addr   (vid_addr),
        .tm_req     (tm_req),
        .tm_addr    (tm_addr),
        .ts_req     (ts_req),
        .ts_addr    (ts_addr),
        .ts_z80_lp  (ts_z80_lp),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .dram_req   (dram_req),
        .dram_addr  (dram_addr),
        .owner      (owner),
        .vid_next   (vid_next),
        .tm_next    (tm_next),
        .ts_pre_next(ts_pre_next),
        .ts_next    (ts_next),
        .cpu_next   (cpu_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    own;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    int   n_checks = 0;
    int   n_errors = 0;
    logic m_rr;
    int   m_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic has_req(input logic [2:0] code);
        case (code)
            O_TM:    return tm_req;
            O_TS:    return ts_req;
            O_CPU:   return cpu_req;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] model_pick();
        logic [2:0] ord[4];
        if (vid_go) return O_VID;
        if (cpu_req && m_wait == MAXW) return O_CPU;
        if (!m_rr) ord = '{O_TM, (ts_z80_lp ? O_CPU : O_IDLE), O_TS, O_CPU};
        else       ord = '{(ts_z80_lp ? O_CPU : O_IDLE), O_TS, O_TM, O_CPU};
        for (int i = 0; i < 4; i++)
            if (has_req(ord[i])) return ord[i];
        return O_IDLE;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [2:0] code);
        case (code)
            O_VID:   return vid_addr;
            O_TM:    return tm_addr;
            O_TS:    return ts_addr;
            O_CPU:   return cpu_addr;
            default: return '0;
        endcase
    endfunction

    task automatic begin_cycle();
        @(negedge clk);
        slot_pre = 1'b0; slot_stb = 1'b0;
        vid_go = 1'b0; tm_req = 1'b0; ts_req = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic set_pre(input logic v, input logic tm, input logic ts, input logic cpu, input logic lp);
        vid_go = v; tm_req = tm; ts_req = ts; cpu_req = cpu; ts_z80_lp = lp;
        vid_addr = AW'($urandom); tm_addr = AW'($urandom);
        ts_addr = AW'($urandom);  cpu_addr = AW'($urandom);
        slot_pre = 1'b1;
        pend.own  = model_pick();
        pend.addr = addr_of(pend.own);
        if (!cpu_req || pend.own == O_CPU) m_wait = 0;
        else if (m_wait < MAXW) m_wait++;
        if (pend.own == O_TM) m_rr = 1'b1;
        else if (pend.own == O_TS) m_rr = 1'b0;
    endtask

    task automatic check_pre();
        check("ts_pre_next", ts_pre_next, pend.own == O_TS);
        sbq.push_back(pend);
    endtask

    task automatic check_stb();
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sbq.pop_front();
        check("dram_req", dram_req, e.own != O_IDLE);
        check("owner", owner, e.own);
        if (e.own != O_IDLE) check("dram_addr", dram_addr, e.addr);
        check("next_pulses", {vid_next, tm_next, ts_next, cpu_next},
              {e.own == O_VID, e.own == O_TM, e.own == O_TS, e.own == O_CPU});
    endtask

    task automatic check_idle();
        check("idle_req", dram_req, 0);
        check("idle_owner", owner, O_IDLE);
        check("idle_next", {vid_next, tm_next, ts_next, cpu_next}, 0);
    endtask

    task automatic run_slot(input logic v, input logic tm, input logic ts, input logic cpu, input logic lp);
        begin_cycle(); set_pre(v, tm, ts, cpu, lp); #1; check_pre(); @(posedge clk);
        begin_cycle(); slot_stb = 1'b1; #1; check_stb(); @(posedge clk);
        begin_cycle(); #1; check_idle(); @(posedge clk);
    endtask

    task automatic reset_mid_slot(input logic tm, input logic ts);
        begin_cycle(); set_pre(1'b0, tm, ts, 1'b0, 1'b0); #1; check_pre(); @(posedge clk);
        @(negedge clk);
        slot_pre = 1'b0; res_n = 1'b0;
        #1;
        check("rst_req", dram_req, 0);
        check("rst_owner", owner, O_IDLE);
        check("rst_addr", dram_addr, 0);
        check("rst_next", {vid_next, tm_next, ts_next, cpu_next, ts_pre_next}, 0);
        sbq.delete();
        m_rr = 1'b0; m_wait = 0;
        @(posedge clk);
        @(negedge clk);
        res_n = 1'b1; slot_stb = 1'b1;
        #1;
        check("stb_after_rst", {vid_next, tm_next, ts_next, cpu_next}, 0);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic b2b;
        res_n = 1'b0; slot_pre = 1'b0; slot_stb = 1'b0;
        vid_go = 1'b0; tm_req = 1'b0; ts_req = 1'b0; cpu_req = 1'b0; ts_z80_lp = 1'b0;
        vid_addr = '0; tm_addr = '0; ts_addr = '0; cpu_addr = '0;
        m_rr = 1'b0; m_wait = 0;
        #12;
        check("reset_req", dram_req, 0);
        check("reset_owner", owner, O_IDLE);
        check("reset_addr", dram_addr, 0);
        check("reset_next", {vid_next, tm_next, ts_next, cpu_next, ts_pre_next}, 0);
        @(negedge clk); res_n = 1'b1;
        @(posedge clk);

        repeat (3) run_slot(1, 1, 1, 1, 0);
        repeat (4) run_slot(0, 1, 1, 0, 0);

        repeat (9) run_slot(1, 0, 0, 1, 0);
        run_slot(0, 1, 0, 1, 0);
        run_slot(0, 1, 0, 1, 0);

        run_slot(0, 0, 1, 1, 1);
        run_slot(0, 0, 1, 1, 0);

        begin_cycle(); set_pre(0, 1, 0, 0, 0); #1; check_pre(); @(posedge clk);
        begin_cycle(); slot_stb = 1'b1; set_pre(0, 0, 1, 0, 0); #1; check_stb(); check_pre(); @(posedge clk);
        begin_cycle(); slot_stb = 1'b1; #1; check_stb(); @(posedge clk);
        begin_cycle(); #1; check_idle(); @(posedge clk);

        reset_mid_slot(1'b0, 1'b1);
        reset_mid_slot(1'b1, 1'b0);
        run_slot(0, 1, 1, 0, 0);
        run_slot(0, 0, 0, 0, 0);

        begin_cycle();
        set_pre($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        #1; check_pre(); @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            begin_cycle();
            slot_stb = 1'b1;
            b2b = 1'($urandom);
            if (b2b)
                set_pre($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1; check_stb();
            if (b2b) check_pre();
            @(posedge clk);
            if (!b2b) begin
                begin_cycle(); #1; check_idle(); @(posedge clk);
                begin_cycle();
                set_pre($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                #1; check_pre(); @(posedge clk);
            end
        end
        begin_cycle(); slot_stb = 1'b1; #1; check_stb(); @(posedge clk);
        begin_cycle(); #1; check_idle(); @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_dram_arb.md
Name: video_dram_arb

Overview:
- Shares the video DRAM slot among four requesters: the raster fetcher, the tilemap reader, the tile/sprite renderer and the Z80.
- One grant is issued per DRAM slot.
- The grant is decided one clock before the slot and presented as a registered address/request pair to the DRAM controller.
- It replaces ad-hoc per-requester slot wiring between the video top and the DRAM controller.

Parameters:
- CPU_MAX_WAIT, 8: number of consecutive lost slots after which a pending Z80 request is force-granted (range 1..15).
- AW, 21: DRAM word address width.

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- slot_pre  in  1  one-clock pulse, one clk before slot_stb; arbitration point
- slot_stb  in  1  one-clock pulse; DRAM slot completes, read data valid
- vid_go  in  1  raster fetch request
- vid_addr  in  AW  raster fetch address
- tm_req  in  1  tilemap request
- tm_addr  in  AW  tilemap address
- ts_req  in  1  TS render request
- ts_addr  in  AW  TS render address
- ts_z80_lp  in  1  1 = Z80 outranks TS renderer
- cpu_req  in  1  Z80 request
- cpu_addr  in  AW  Z80 address
- dram_req  out  1  slot claimed
- dram_addr  out  AW  address for claimed slot
- owner  out  3  current owner: IDLE=0, VID=1, TM=2, TS=3, CPU=4
- vid_next  out  1  grant-complete pulse, raster
- tm_next  out  1  grant-complete pulse, tilemap
- ts_pre_next  out  1  early grant pulse, TS
- ts_next  out  1  grant-complete pulse, TS
- cpu_next  out  1  grant-complete pulse, Z80

Behaviour:
- Reset (async, res_n=0):
  - dram_req=0, dram_addr=0, owner=IDLE, all *_next=0, ts_pre_next=0, rr=0, wait_cnt=0.
  - Any reset mid-slot drops the slot: no next pulse is issued for it.
- Arbitration at slot_pre:
  - Requests and addresses are sampled only in the slot_pre cycle.
  - The winner is registered into owner/dram_addr and dram_req=1 from the next clock through the slot_stb cycle.
  - A request dropped after sampling is still served; the slot is committed.
- Priority, evaluated top to bottom:
  1. vid_go.
  2. cpu_req when wait_cnt == CPU_MAX_WAIT.
  3. Round-robin pair: tm then ts when rr=0; ts then tm when rr=1. When ts_z80_lp=1, cpu_req is inserted immediately ahead of ts in this order.
  4. cpu_req.
  5. IDLE.
- ts_pre_next: one-clock pulse in the slot_pre cycle whenever TS wins (combinational from the decision).
- Round-robin pointer: on a TM grant rr<=1; on a TS grant rr<=0; otherwise unchanged.
- wait_cnt (4-bit) at each slot_pre:
  - cpu_req=0: set to 0.
  - CPU granted: set to 0.
  - Otherwise: increment, saturating at CPU_MAX_WAIT.
- Slot completion:
  - At slot_stb, the owner's *_next pulses for exactly one clock.
  - In the clock after slot_stb, dram_req=0 and owner=IDLE, unless the same cycle was also a slot_pre.
- slot_pre and slot_stb in the same cycle (back-to-back slots):
  - The current owner's next pulse fires.
  - The new grant loads without a gap cycle; dram_req stays 1 if the new winner is not IDLE.
- slot_stb with owner=IDLE: no pulses.
- slot_pre while a slot is still open with no slot_stb: protocol violation; the new decision overwrites the open slot and no next pulse is issued for the lost slot. Assert in simulation.
- Latency: request sampled at slot_pre T; dram_req at T+1; next pulse at the slot_stb cycle.

Decomposition:
- Package video_arb_pkg holds the owner encoding constants (IDLE/VID/TM/TS/CPU) and the owner width.
- One natural sub-module: video_arb_pick, a combinational priority/round-robin selector taking the requests, rr, ts_z80_lp and the starve flag, and returning the owner code. The top module keeps all registers.

Test Plan:
- vid_go=1 and tm_req=ts_req=cpu_req=1 for 3 slots -> owner=VID every slot, vid_next 3 pulses, wait_cnt reaches 3.
- tm_req=ts_req=1, others 0, rr=0 after reset, 4 slots -> grant order TM, TS, TM, TS; tm_next/ts_next alternate; ts_pre_next aligned to slot_pre on TS slots.
- vid_go held 1 with cpu_req=1 and CPU_MAX_WAIT=8 -> VID keeps every slot (VID outranks the starve grant); drop vid_go with tm_req=1 -> CPU granted first, because wait_cnt saturated at 8, then TM.
- ts_z80_lp=1, rr=1, ts_req=cpu_req=1 -> CPU wins, dram_addr=cpu_addr; with ts_z80_lp=0 the same inputs -> TS wins.
- Back-to-back slot_pre+slot_stb same cycle, TM then TS -> tm_next pulse and new owner=TS loaded in that cycle, dram_req never deasserts.
- res_n=0 pulsed between slot_pre and slot_stb of a TS grant -> all outputs 0 immediately, no ts_next at the following slot_stb, rr=0.
